// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, transaction owner,
// and the width of the read-latency down-counter (MEM_LAT is at most 15).
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OWN_CORE,
    OWN_EXT
  } owner_t;

  localparam int LAT_W = 4;

endpackage

// File: rtl/dmem_arb_pick.sv
// Grant selector for the data-memory arbiter. The core wins by default. The
// ext port is forced to win once the core has taken STARVE_MAX consecutive
// grants while ext was waiting.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   core_req,
  input  logic   ext_req,
  input  logic   grant,
  output owner_t owner
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

  // Priority pick: ext wins only when it is alone or has been starved.
  always_comb begin
    owner = OWN_CORE;
    if (ext_req && (!core_req || starved)) owner = OWN_EXT;
  end

  // Starvation counter: counts contested core grants, clears on an ext grant.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (owner == OWN_EXT) begin
        starve_cnt <= '0;
      end else if (ext_req && !starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the core memory stage and an
// external loader/debug master. It runs an IDLE/ISSUE/WAIT/RESP access FSM
// with a fixed read latency of MEM_LAT cycles.
// Optional build macro DMEM_ARB_ALIGN_CHK_EN: adds core_err/ext_err. When it
// is set, an access to a misaligned word skips the memory and completes with
// err.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic              core_done,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_done,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef DMEM_ARB_ALIGN_CHK_EN
  ,
  output logic              core_err,
  output logic              ext_err
`endif
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

  state_t            state, state_nxt;
  owner_t            owner_q, pick_owner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LAT_W-1:0]  lat_cnt;
  logic [DATA_W-1:0] core_rdata_q, ext_rdata_q;
  logic              grant;
  logic              misalign;
  logic              rd_resp;

  assign grant = (state == IDLE) && (core_req || ext_req);

`ifdef DMEM_ARB_ALIGN_CHK_EN
  assign misalign = (addr_q[1:0] != 2'b00);
  assign core_err = (state == RESP) && (owner_q == OWN_CORE) && misalign;
  assign ext_err  = (state == RESP) && (owner_q == OWN_EXT) && misalign;
`else
  assign misalign = 1'b0;
`endif

  // A read that actually touched memory returns data in RESP.
  assign rd_resp = (state == RESP) && !we_q && !misalign;

  dmem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk     (clk),
    .rst     (rst),
    .core_req(core_req),
    .ext_req (ext_req),
    .grant   (grant),
    .owner   (pick_owner)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Latch the winning request's fields at grant.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the latched fields are reset because they drive mem_addr and
    // mem_wdata directly, and those must read zero after reset.
    if (rst) begin
      owner_q <= OWN_CORE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      owner_q <= pick_owner;
      we_q    <= (pick_owner == OWN_EXT) ? ext_we    : core_we;
      addr_q  <= (pick_owner == OWN_EXT) ? ext_addr  : core_addr;
      wdata_q <= (pick_owner == OWN_EXT) ? ext_wdata : core_wdata;
    end
  end

  // Read-latency down-counter: loaded in ISSUE, counts down through WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 lat_cnt <= '0;
    else if (state == ISSUE) lat_cnt <= LAT_INIT;
    else if (state == WAIT)  lat_cnt <= lat_cnt - LAT_W'(1);
  end

  // Held load data per port; each register changes only on its own read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rdata_q <= '0;
      ext_rdata_q  <= '0;
    end else if (rd_resp) begin
      if (owner_q == OWN_EXT) ext_rdata_q  <= mem_rdata;
      else                    core_rdata_q <= mem_rdata;
    end
  end

  // Next-state and output decode.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    core_done = 1'b0;
    ext_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_en = !misalign;
        mem_we = we_q && !misalign;
        if (we_q || misalign || (MEM_LAT == 1)) state_nxt = RESP;
        else                                    state_nxt = WAIT;
      end
      WAIT: begin
        if (lat_cnt == LAT_W'(1)) state_nxt = RESP;
      end
      RESP: begin
        core_done = (owner_q == OWN_CORE);
        ext_done  = (owner_q == OWN_EXT);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = (state != IDLE);
  assign core_stall = core_req && !core_done;
  assign core_rdata = (rd_resp && owner_q == OWN_CORE) ? mem_rdata : core_rdata_q;
  assign ext_rdata  = (rd_resp && owner_q == OWN_EXT)  ? mem_rdata : ext_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. Expected completions go into a scoreboard
// queue as stimulus is driven. Each done pulse pops an entry and compares
// port, data and (with DMEM_ARB_ALIGN_CHK_EN) err.
module tb_dmem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              core_req, core_we, ext_req, ext_we;
  logic [ADDR_W-1:0] core_addr, ext_addr;
  logic [DATA_W-1:0] core_wdata, ext_wdata;
  logic              core_stall, core_done, ext_done;
  logic [DATA_W-1:0] core_rdata, ext_rdata;
  logic              mem_en, mem_we, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_ALIGN_CHK_EN
  logic              core_err, ext_err;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_stall(core_stall), .core_done(core_done),
    .core_rdata(core_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_done(ext_done), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef DMEM_ARB_ALIGN_CHK_EN
    , .core_err(core_err), .ext_err(ext_err)
`endif
  );

  // Memory model: 64 words. Unwritten words return a fixed pattern. Read data
  // appears MEM_LAT cycles after mem_en, and a poison value shows otherwise.
  logic [31:0] mem [64];
  logic [63:0] written = '0;
  logic [31:0] pipe [MEM_LAT];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hDEADBEEF;
      32'h20:  return 32'hCAFEF00D;
      default: return {16'hA5A5, a[15:0]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_en && !mem_we)
      pipe[0] <= written[mem_addr[7:2]] ? mem[mem_addr[7:2]] : init_word(mem_addr);
    else
      pipe[0] <= 32'hBAD0BAD0;
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    if (mem_en && mem_we) begin
      mem[mem_addr[7:2]]     <= mem_wdata;
      written[mem_addr[7:2]] <= 1'b1;
    end
  end
  assign mem_rdata = pipe[MEM_LAT-1];

  typedef struct {
    logic        is_ext;
    logic        chk_rdata;
    logic [31:0] rdata;
    logic        err;
    logic        drop;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          c0;
  int          done_at[$];
  int          mem_en_cnt, stall_bad, done_cnt;
  logic        iss_we;
  logic [31:0] iss_addr, iss_wdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and sample the monitors there.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mem_en === 1'b1) begin
      mem_en_cnt++;
      iss_we    = mem_we;
      iss_addr  = mem_addr;
      iss_wdata = mem_wdata;
    end
    if (core_req === 1'b1 && core_done !== 1'b1 && core_stall !== 1'b1) stall_bad++;
    if ((core_req === 1'b0 || core_done === 1'b1) && core_stall !== 1'b0) stall_bad++;
    if (core_done === 1'b1 || ext_done === 1'b1) done_cnt++;
  endtask

  task automatic clr();
    mem_en_cnt = 0;
    stall_bad  = 0;
    done_cnt   = 0;
    done_at.delete();
    c0 = cyc;
  endtask

  task automatic expect_done(input logic is_ext, input logic chk, input logic [31:0] rd,
                             input logic err, input logic drop);
    exp_t e;
    e.is_ext    = is_ext;
    e.chk_rdata = chk;
    e.rdata     = rd;
    e.err       = err;
    e.drop      = drop;
    sb.push_back(e);
  endtask

  task automatic drive_core(input logic we, input logic [31:0] a, input logic [31:0] d);
    core_we = we; core_addr = a; core_wdata = d; core_req = 1'b1;
  endtask

  task automatic drive_ext(input logic we, input logic [31:0] a, input logic [31:0] d);
    ext_we = we; ext_addr = a; ext_wdata = d; ext_req = 1'b1;
  endtask

  task automatic take_done(input logic is_ext);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL unexpected_done port=%0d expected=none", is_ext);
      return;
    end
    e = sb.pop_front();
    check("done_port", {63'b0, is_ext}, {63'b0, e.is_ext});
    if (e.chk_rdata) check("rdata", is_ext ? ext_rdata : core_rdata, e.rdata);
`ifdef DMEM_ARB_ALIGN_CHK_EN
    check("err", is_ext ? ext_err : core_err, e.err);
`endif
    done_at.push_back(cyc);
    if (e.drop) begin
      if (is_ext) ext_req = 1'b0;
      else        core_req = 1'b0;
    end
  endtask

  // Wait for ndone completions within a cycle budget.
  task automatic run(input int ndone, input int budget);
    int got = 0;
    int n = 0;
    while (got < ndone && n < budget) begin
      tick();
      n++;
      if (core_done === 1'b1) begin take_done(1'b0); got++; end
      if (ext_done === 1'b1)  begin take_done(1'b1); got++; end
    end
    check("run_done_count", got, ndone);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;

    // Reset state.
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_core_done", core_done, 0);
    check("rst_ext_done", ext_done, 0);
    check("rst_core_rdata", core_rdata, 0);
    check("rst_ext_rdata", ext_rdata, 0);
    check("rst_stall_req1", core_stall, 1);
    core_req = 1'b0;
    #1;
    check("rst_stall_req0", core_stall, 0);
    rst = 1'b0;
    tick();

    // Core load from 0x10.
    clr();
    drive_core(1'b0, 32'h10, 32'h0);
    expect_done(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    run(1, 10);
    check("ld_latency", done_at[0] - c0, MEM_LAT + 1);
    check("ld_mem_en_cycles", mem_en_cnt, 1);
    check("ld_mem_we", iss_we, 0);
    check("ld_mem_addr", iss_addr, 32'h10);
    check("ld_stall", stall_bad, 0);
    tick();
    check("ld_rdata_held", core_rdata, 32'hDEADBEEF);
    check("ld_idle_busy", busy, 0);

    // Core store to 0x8, then ext readback.
    clr();
    drive_core(1'b1, 32'h8, 32'h12345678);
    expect_done(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    run(1, 10);
    check("st_latency", done_at[0] - c0, 2);
    check("st_mem_en_cycles", mem_en_cnt, 1);
    check("st_mem_we", iss_we, 1);
    check("st_mem_addr", iss_addr, 32'h8);
    check("st_mem_wdata", iss_wdata, 32'h12345678);
    tick();
    clr();
    drive_ext(1'b0, 32'h8, 32'h0);
    expect_done(1'b1, 1'b1, 32'h12345678, 1'b0, 1'b1);
    run(1, 10);
    check("rb_latency", done_at[0] - c0, MEM_LAT + 1);
    tick();
    check("rb_ext_rdata_held", ext_rdata, 32'h12345678);

    // Ext read in flight; core request arrives and must wait its turn.
    clr();
    drive_ext(1'b0, 32'h20, 32'h0);
    expect_done(1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    tick();
    drive_core(1'b0, 32'h10, 32'h0);
    expect_done(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    run(2, 20);
    check("cont_core_gap", done_at[1] - done_at[0], MEM_LAT + 2);
    check("cont_ext_rdata_kept", ext_rdata, 32'hCAFEF00D);
    check("cont_stall", stall_bad, 0);
    tick();

    // Reset asserted during WAIT aborts the access with no done pulse.
    drive_core(1'b0, 32'h20, 32'h0);
    tick();
    tick();
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_mem_en", mem_en, 0);
    check("abort_core_done", core_done, 0);
    check("abort_stall", core_stall, 1);
    check("abort_core_rdata", core_rdata, 0);
    core_req = 1'b0;
    clr();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("abort_no_done", done_cnt, 0);
    clr();
    drive_core(1'b0, 32'h10, 32'h0);
    expect_done(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    run(1, 10);
    check("post_rst_latency", done_at[0] - c0, MEM_LAT + 1);
    tick();

    // Both ports request continuously: four core grants, then one ext grant.
    clr();
    drive_core(1'b0, 32'h10, 32'h0);
    drive_ext(1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 10; i++)
      if (i % 5 == 4) expect_done(1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
      else            expect_done(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    run(10, 10 * (MEM_LAT + 2) + 10);
    core_req = 1'b0;
    ext_req  = 1'b0;
    check("starve_total_cycles", done_at[9] - done_at[0], 9 * (MEM_LAT + 2));
    tick();

    // Dropping req after the grant does not cancel the access.
    clr();
    drive_core(1'b0, 32'h20, 32'h0);
    tick();
    core_req = 1'b0;
    expect_done(1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    run(1, 10);
    check("drop_latency", done_at[0] - c0, MEM_LAT + 1);
    tick();

`ifdef DMEM_ARB_ALIGN_CHK_EN
    // Misaligned load skips memory and keeps the held rdata.
    clr();
    drive_core(1'b0, 32'h6, 32'h0);
    expect_done(1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b1);
    run(1, 10);
    check("align_latency", done_at[0] - c0, 2);
    check("align_mem_en_cycles", mem_en_cnt, 0);
    tick();
    check("align_rdata_kept", core_rdata, 32'hCAFEF00D);
`endif

    check("final_busy", busy, 0);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
